// File: rtl/event_period_meter_pkg.sv
// Shared types and constants for event_period_meter.
package event_period_meter_pkg;

  typedef enum logic {
    ST_IDLE,
    ST_MEASURE
  } state_t;

  // All-ones value of a w-bit counter, usable in localparam expressions.
  function automatic logic [31:0] cnt_max(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/event_period_meter_rise_detect.sv
// Single-flop rising-edge detector for a signal synchronous to in_clk.
module rise_detect (
  input  logic in_clk,
  input  logic in_res,
  input  logic in_sig,
  output logic out_rise
);

  logic prev_q;

  always_ff @(posedge in_clk) begin
    if (in_res) prev_q <= 1'b0;
    else        prev_q <= in_sig;
  end

  assign out_rise = in_sig & ~prev_q;

endmodule

// File: rtl/event_period_meter.sv
// Measures cycles between rising edges of in_event into a valid/ack holding register.
// Optional running min/max outputs when EVENT_PERIOD_METER_MINMAX_EN is defined.
module event_period_meter
  import event_period_meter_pkg::*;
#(
  parameter int unsigned n = 8
) (
  input  logic         in_clk,
  input  logic         in_res,
  input  logic         in_event,
  input  logic         in_enable,
  input  logic         in_ack,
  input  logic         in_clear,
  output logic [n-1:0] out_period,
  output logic         out_overflow,
  output logic         out_valid,
  output logic         out_lost,
  output logic         out_busy
`ifdef EVENT_PERIOD_METER_MINMAX_EN
  ,
  output logic [n-1:0] out_min,
  output logic [n-1:0] out_max
`endif
);

  localparam logic [31:0]  CNT_MAX_W = cnt_max(n);
  localparam logic [n-1:0] CNT_MAX   = CNT_MAX_W[n-1:0];
  localparam logic [n-1:0] CNT_ONE   = {{(n-1){1'b0}}, 1'b1};

  logic rise;

  rise_detect u_rise (
    .in_clk  (in_clk),
    .in_res  (in_res),
    .in_sig  (in_event),
    .out_rise(rise)
  );

  state_t       state_q, state_d;
  logic [n-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;
  logic         capture;

  logic [n-1:0] period_q, period_d;
  logic         ovf_q, ovf_d;
  logic         valid_q, valid_d;
  logic         lost_q, lost_d;

  always_ff @(posedge in_clk) begin
    if (in_res) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      period_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sat_q    <= sat_d;
      period_q <= period_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      lost_q   <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_enable && rise) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_ONE;
          sat_d   = 1'b0;
        end
      end
      ST_MEASURE: begin
        if (!in_enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          sat_d   = 1'b0;
        end else if (rise) begin
          capture = 1'b1;
          cnt_d   = CNT_ONE;
          sat_d   = 1'b0;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
          // Flag goes up in the same step the counter reaches its ceiling.
          if (cnt_q == CNT_MAX - CNT_ONE) sat_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    period_d = period_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    lost_d   = lost_q;
    if (in_clear) lost_d = 1'b0;
    if (capture) begin
      if (!valid_q || in_ack) begin
        period_d = cnt_q;
        ovf_d    = sat_q;
        valid_d  = 1'b1;
      end else begin
        lost_d = 1'b1;
      end
    end else if (in_ack && valid_q) begin
      valid_d = 1'b0;
    end
  end

  assign out_period   = period_q;
  assign out_overflow = ovf_q;
  assign out_valid    = valid_q;
  assign out_lost     = lost_q;
  assign out_busy     = (state_q == ST_MEASURE);

`ifdef EVENT_PERIOD_METER_MINMAX_EN
  logic [n-1:0] min_q, min_d;
  logic [n-1:0] max_q, max_d;

  always_ff @(posedge in_clk) begin
    if (in_res) begin
      min_q <= CNT_MAX;
      max_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
    end
  end

  // A clear coinciding with a capture restarts the statistics from that capture.
  always_comb begin
    min_d = min_q;
    max_d = max_q;
    if (in_clear) begin
      min_d = CNT_MAX;
      max_d = '0;
    end
    if (capture) begin
      if (!sat_q && (cnt_q < min_d)) min_d = cnt_q;
      if (cnt_q > max_d) max_d = cnt_q;
    end
  end

  assign out_min = min_q;
  assign out_max = max_q;
`endif

endmodule
